// File: rtl/code2_decode_stage.sv
// Decode stage for the code2 core: register file with write-back bypass, a busy-bit
// scoreboard for pending destinations, and a valid/ready output register with flush.
module code2_decode_stage #(
  parameter int I        = 24,
  parameter int P        = 16,
  parameter int D        = 32,
  parameter int R        = 5,
  parameter int F        = 3,
  parameter int ZERO_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [I-1:0] instr_i,
  input  logic [P-1:0] next_pc_i,
  input  logic         we3_i,
  input  logic [R-1:0] wa3_i,
  input  logic [D-1:0] wd3_i,
  input  logic         flush_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic         op_o,
  output logic [F-1:0] funct3_o,
  output logic [R-1:0] rd_o,
  output logic [D-1:0] rs_o,
  output logic [D-1:0] rt_o,
  output logic [D-1:0] imm_o,
  output logic [P-1:0] next_pc_o
);

  localparam int NREG = 2 ** R;
  localparam int IW   = I - 3 * R - F - 1;

  logic [D-1:0]    regs_q [NREG];
  logic [D-1:0]    regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d, busy_eff;
  logic            valid_q, valid_d;
  logic            op_q, op_d;
  logic [F-1:0]    funct3_q, funct3_d;
  logic [R-1:0]    rd_q, rd_d;
  logic [D-1:0]    rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
  logic [P-1:0]    next_pc_q, next_pc_d;

  logic [R-1:0]  rs_idx, rt_idx, rd_idx;
  logic [IW-1:0] imm_raw;
  logic [D-1:0]  imm_ext, rs_val, rt_val;
  logic          wb_ok, rd_writable, hz, load, ready, accept;

  assign rs_idx  = instr_i[R+F:F+1];
  assign rt_idx  = instr_i[2*R+F:R+F+1];
  assign rd_idx  = instr_i[3*R+F:2*R+F+1];
  assign imm_raw = instr_i[I-1:3*R+F+1];
  assign imm_ext = {{(D-IW){imm_raw[IW-1]}}, imm_raw};

  assign wb_ok       = we3_i && !((ZERO_REG != 0) && (wa3_i == '0));
  assign rd_writable = !((ZERO_REG != 0) && (rd_idx == '0));

  // Register 0 is never set busy, so it needs no special case here.
  always_comb begin
    busy_eff = busy_q;
    for (int x = 0; x < NREG; x++) begin
      if (wb_ok && (wa3_i == R'(x))) busy_eff[x] = 1'b0;
    end
  end

  always_comb begin
    rs_val = regs_q[rs_idx];
    rt_val = regs_q[rt_idx];
    if (wb_ok && (wa3_i == rs_idx)) rs_val = wd3_i;
    if (wb_ok && (wa3_i == rt_idx)) rt_val = wd3_i;
    if ((ZERO_REG != 0) && (rs_idx == '0)) rs_val = '0;
    if ((ZERO_REG != 0) && (rt_idx == '0)) rt_val = '0;
  end

  assign hz      = busy_eff[rs_idx] | busy_eff[rt_idx] | busy_eff[rd_idx];
  assign load    = !valid_q || ready_i;
  assign ready   = load && !hz && !flush_i;
  assign accept  = valid_i && ready;
  assign ready_o = ready;

  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    op_d      = op_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    imm_d     = imm_q;
    next_pc_d = next_pc_q;

    if (wb_ok) regs_d[wa3_i] = wd3_i;

    if (flush_i) begin
      valid_d = 1'b0;
      busy_d  = '0;
    end else begin
      // Clear first so a same-cycle set of the same index wins.
      busy_d = busy_eff;
      if (accept) begin
        valid_d   = 1'b1;
        op_d      = instr_i[0];
        funct3_d  = instr_i[F:1];
        rd_d      = rd_idx;
        rs_d      = rs_val;
        rt_d      = rt_val;
        imm_d     = imm_ext;
        next_pc_d = next_pc_i;
        if (rd_writable) busy_d[rd_idx] = 1'b1;
      end else if (load) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      busy_q    <= '0;
      valid_q   <= 1'b0;
      op_q      <= 1'b0;
      funct3_q  <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      next_pc_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      imm_q     <= imm_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign valid_o   = valid_q;
  assign op_o      = op_q;
  assign funct3_o  = funct3_q;
  assign rd_o      = rd_q;
  assign rs_o      = rs_q;
  assign rt_o      = rt_q;
  assign imm_o     = imm_q;
  assign next_pc_o = next_pc_q;

endmodule

// File: tb/tb_code2_decode_stage.sv
// Bench for code2_decode_stage: directed scenarios then random traffic, all checked
// against a behavioural model of registers, busy flags and the output slot.
module tb_code2_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, we3_i, flush_i, ready_i, valid_o, op_o;
  logic [23:0] instr_i;
  logic [15:0] next_pc_i, next_pc_o;
  logic [4:0]  wa3_i, rd_o;
  logic [31:0] wd3_i, rs_o, rt_o, imm_o;
  logic [2:0]  funct3_o;

  code2_decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .next_pc_i(next_pc_i), .we3_i(we3_i), .wa3_i(wa3_i),
    .wd3_i(wd3_i), .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o),
    .op_o(op_o), .funct3_o(funct3_o), .rd_o(rd_o), .rs_o(rs_o), .rt_o(rt_o),
    .imm_o(imm_o), .next_pc_o(next_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  bit [31:0] m_regs [32];
  bit        m_busy [32];
  bit        m_valid, m_op;
  bit [2:0]  m_f3;
  bit [4:0]  m_rd;
  bit [31:0] m_rs, m_rt, m_imm;
  bit [15:0] m_pc;
  logic      last_ready;
  bit [15:0] pc_ctr = 16'h0100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [23:0] mk(input int imm, input int rd, input int rt, input int rs,
                                   input int f3, input int op);
    return 24'(imm * (1 << 19) + rd * (1 << 14) + rt * (1 << 9) + rs * (1 << 4) + f3 * 2 + op);
  endfunction

  function automatic bit m_beff(input int idx, input bit we, input int wa);
    return m_busy[idx] && !(we && wa == idx && wa != 0);
  endfunction

  function automatic bit [31:0] m_read(input int idx, input bit we, input int wa, input bit [31:0] wd);
    if (idx == 0) return 32'h0;
    if (we && wa == idx) return wd;
    return m_regs[idx];
  endfunction

  task automatic step(input bit v, input bit [23:0] ins, input bit rdy, input bit we,
                      input bit [4:0] wa, input bit [31:0] wd, input bit fl, input bit rs_in);
    int irs, irt, ird, imm5;
    bit mrdy, acc;
    bit [31:0] n_rs, n_rt, n_imm;
    valid_i = v; instr_i = ins; ready_i = rdy; we3_i = we; wa3_i = wa; wd3_i = wd;
    flush_i = fl; rst_i = rs_in; next_pc_i = pc_ctr;
    #1;
    irs  = (int'(ins) >> 4) % 32;
    irt  = (int'(ins) >> 9) % 32;
    ird  = (int'(ins) >> 14) % 32;
    imm5 = int'(ins) >> 19;
    mrdy = (!m_valid || rdy) && !fl &&
           !(m_beff(irs, we, wa) || m_beff(irt, we, wa) || m_beff(ird, we, wa));
    acc  = v && mrdy;
    n_rs  = m_read(irs, we, wa, wd);
    n_rt  = m_read(irt, we, wa, wd);
    n_imm = (imm5 >= 16) ? 32'(imm5 - 32) : 32'(imm5);
    last_ready = ready_o;
    if (!rs_in) check("ready_o", ready_o, mrdy);
    @(posedge clk_i);
    if (rs_in) begin
      for (int k = 0; k < 32; k++) begin m_regs[k] = 0; m_busy[k] = 0; end
      m_valid = 0; m_op = 0; m_f3 = 0; m_rd = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_pc = 0;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (fl) begin
        m_valid = 0;
        for (int k = 0; k < 32; k++) m_busy[k] = 0;
      end else begin
        if (we && wa != 0) m_busy[wa] = 0;
        if (acc) begin
          m_valid = 1; m_op = ins[0]; m_f3 = 3'((int'(ins) >> 1) % 8); m_rd = 5'(ird);
          m_rs = n_rs; m_rt = n_rt; m_imm = n_imm; m_pc = pc_ctr;
          if (ird != 0) m_busy[ird] = 1;
        end else if (!m_valid || rdy) begin
          m_valid = 0;
        end
      end
    end
    pc_ctr = pc_ctr + 16'd1;
    #1;
    check("valid_o", valid_o, m_valid);
    check("op_o", op_o, m_op);
    check("funct3_o", funct3_o, m_f3);
    check("rd_o", rd_o, m_rd);
    check("rs_o", rs_o, m_rs);
    check("rt_o", rt_o, m_rt);
    check("imm_o", imm_o, m_imm);
    check("next_pc_o", next_pc_o, m_pc);
  endtask

  initial begin
    rst_i = 1; valid_i = 0; instr_i = 0; ready_i = 1; we3_i = 0; wa3_i = 0;
    wd3_i = 0; flush_i = 0; next_pc_i = 0;

    // 1: basic decode
    step(0, 0, 1, 0, 0, 0, 0, 1);
    check("reset_valid", valid_o, 1'b0);
    check("reset_rs", rs_o, 32'h0);
    step(0, 0, 1, 1, 4, 32'h11, 0, 0);
    step(0, 0, 1, 1, 9, 32'h22, 0, 0);
    step(1, mk(31, 3, 9, 4, 5, 1), 1, 0, 0, 0, 0, 0);
    check("t1_valid", valid_o, 1'b1);
    check("t1_rs", rs_o, 32'h11);
    check("t1_rt", rt_o, 32'h22);
    check("t1_rd", rd_o, 5'd3);
    check("t1_f3", funct3_o, 3'd5);
    check("t1_op", op_o, 1'b1);
    check("t1_imm", imm_o, 32'hFFFF_FFFF);

    // 2: write-back bypass
    step(1, mk(2, 5, 0, 7, 1, 0), 1, 1, 7, 32'hABCD, 0, 0);
    check("t2_bypass", rs_o, 32'hABCD);

    // 3: RAW stall on r3 until its write-back
    step(1, mk(0, 6, 0, 3, 0, 0), 1, 0, 0, 0, 0, 0);
    check("t3_stall0", last_ready, 1'b0);
    step(1, mk(0, 6, 0, 3, 0, 0), 1, 0, 0, 0, 0, 0);
    check("t3_stall1", last_ready, 1'b0);
    step(1, mk(0, 6, 0, 3, 0, 0), 1, 1, 3, 32'h333, 0, 0);
    check("t3_release", last_ready, 1'b1);
    check("t3_rs", rs_o, 32'h333);

    // 4: backpressure holds everything
    for (int i = 0; i < 3; i++) begin
      step(1, mk(0, 7, 0, 1, 2, 1), 0, 0, 0, 0, 0, 0);
      check("t4_ready", last_ready, 1'b0);
      check("t4_hold_rs", rs_o, 32'h333);
      check("t4_hold_rd", rd_o, 5'd6);
    end
    step(1, mk(0, 7, 0, 1, 2, 1), 1, 0, 0, 0, 0, 0);
    check("t4_capture_rd", rd_o, 5'd7);

    // 5: flush clears the scoreboard
    step(1, mk(0, 3, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    step(1, mk(0, 4, 0, 3, 0, 0), 1, 0, 0, 0, 1, 0);
    check("t5_flush_valid", valid_o, 1'b0);
    step(1, mk(0, 2, 0, 3, 0, 0), 1, 0, 0, 0, 0, 0);
    check("t5_no_stall", last_ready, 1'b1);
    check("t5_valid", valid_o, 1'b1);

    // 6: register 0 is hardwired
    step(0, 0, 1, 1, 0, 32'h55, 0, 0);
    step(1, mk(0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    check("t6_r0", rs_o, 32'h0);
    step(1, mk(0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0);
    check("t6_no_stall", last_ready, 1'b1);

    // random traffic
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 3) != 0,
           mk($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
